// File: rtl/pdm_to_pcm.sv
// rtl/pdm_to_pcm.sv - boxcar PDM-to-PCM decimator feeding a show-ahead output FIFO
// Define DC_BLOCK_EN to insert a first-order DC blocker between conversion and FIFO push.
module pdm_to_pcm #(
    parameter int DECIM      = 64,
    parameter int PCM_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DC_SHIFT   = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          mclk_en,
    input  logic                          pdm_bit,
    output logic [PCM_W-1:0]              pcm_data,
    output logic                          pcm_valid,
    input  logic                          pcm_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          clr_ovr
);

    localparam int CW    = $clog2(DECIM);
    localparam int SHIFT = PCM_W - CW - 1;
    localparam int WW    = PCM_W + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;

    localparam logic [CW-1:0]    LAST_IDX = CW'(DECIM - 1);
    localparam logic [WW-1:0]    DECIM_W  = WW'(DECIM);
    localparam logic [PCM_W-1:0] PCM_MAX  = {1'b0, {(PCM_W-1){1'b1}}};
    localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);

    logic [CW-1:0]    bit_idx_q, bit_idx_d;
    logic [CW:0]      ones_q, ones_d;
    logic [CW:0]      count;
    logic             win_end;
    logic [WW-1:0]    c_ext, wide;
    logic [PCM_W-1:0] conv_word;

    always_comb begin
        count     = ones_q + {{CW{1'b0}}, pdm_bit};
        win_end   = en && mclk_en && (bit_idx_q == LAST_IDX);
        bit_idx_d = bit_idx_q;
        ones_d    = ones_q;
        if (!en) begin
            bit_idx_d = '0;
            ones_d    = '0;
        end else if (mclk_en) begin
            if (win_end) begin
                bit_idx_d = '0;
                ones_d    = '0;
            end else begin
                bit_idx_d = bit_idx_q + 1'b1;
                ones_d    = count;
            end
        end
    end

    // (2c - DECIM) scaled to full range; only c == DECIM can exceed the positive limit.
    always_comb begin
        c_ext     = WW'(count);
        wide      = ((c_ext << 1) - DECIM_W) << SHIFT;
        conv_word = (!wide[PCM_W] && wide[PCM_W-1]) ? PCM_MAX : wide[PCM_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx_q <= '0;
            ones_q    <= '0;
        end else begin
            bit_idx_q <= bit_idx_d;
            ones_q    <= ones_d;
        end
    end

    logic             push_v_q, push_v_d;
    logic [PCM_W-1:0] push_data_q, push_data_d;

`ifdef DC_BLOCK_EN
    localparam int YW = PCM_W + 2;
    localparam logic signed [YW-1:0] Y_MAX = YW'(PCM_MAX);
    localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

    logic                    x_v_q, x_v_d;
    logic signed [PCM_W-1:0] x_q, x_d;
    logic signed [PCM_W-1:0] x_prev_q, x_prev_d;
    logic signed [PCM_W-1:0] y_prev_q, y_prev_d;
    logic signed [PCM_W-1:0] y_shift;
    logic signed [YW-1:0]    y_wide;
    logic signed [PCM_W-1:0] y_sat;

    always_comb begin
        x_v_d   = win_end;
        x_d     = win_end ? conv_word : x_q;
        y_shift = y_prev_q >>> DC_SHIFT;
        y_wide  = {{2{x_q[PCM_W-1]}}, x_q} - {{2{x_prev_q[PCM_W-1]}}, x_prev_q}
                + {{2{y_prev_q[PCM_W-1]}}, y_prev_q} - {{2{y_shift[PCM_W-1]}}, y_shift};
        if (y_wide > Y_MAX)
            y_sat = PCM_MAX;
        else if (y_wide < Y_MIN)
            y_sat = ~PCM_MAX;
        else
            y_sat = y_wide[PCM_W-1:0];
        x_prev_d    = x_prev_q;
        y_prev_d    = y_prev_q;
        if (!en) begin
            x_prev_d = '0;
            y_prev_d = '0;
        end else if (x_v_q) begin
            x_prev_d = x_q;
            y_prev_d = y_sat;
        end
        push_v_d    = x_v_q;
        push_data_d = x_v_q ? y_sat : push_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_v_q    <= 1'b0;
            x_q      <= '0;
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            x_v_q    <= x_v_d;
            x_q      <= x_d;
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
        end
    end
`else
    always_comb begin
        push_v_d    = win_end;
        push_data_d = win_end ? conv_word : push_data_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_v_q    <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_v_q    <= push_v_d;
            push_data_q <= push_data_d;
        end
    end

    logic [PCM_W-1:0] mem_q [FIFO_DEPTH];
    logic [PCM_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovr_q, ovr_d;
    logic             full, pop, do_push, drop;

    // When full, a coinciding pop frees the head slot the push lands in.
    always_comb begin
        full     = (level_q == FULL_LVL);
        pop      = (level_q != '0) && pcm_ready;
        do_push  = push_v_q && (!full || pop);
        drop     = push_v_q && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !pop)
            level_d = level_q + 1'b1;
        else if (!do_push && pop)
            level_d = level_q - 1'b1;
        ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
        end
    end

    assign pcm_data   = mem_q[rd_ptr_q];
    assign pcm_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pdm_to_pcm.sv
// tb/tb_pdm_to_pcm.sv - self-checking bench for pdm_to_pcm (default build)
module tb_pdm_to_pcm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        mclk_en = 1'b0;
    logic        pdm_bit = 1'b0;
    logic        pcm_ready = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic [2:0]  fifo_level;
    logic        overrun;

    pdm_to_pcm dut (
        .clk(clk), .reset(reset), .en(en), .mclk_en(mclk_en), .pdm_bit(pdm_bit),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .fifo_level(fifo_level), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] mq[$];
    bit          m_ovr = 0;
    bit          m_pend = 0;
    logic [15:0] m_pend_w = '0;
    int          m_idx = 0;
    int          m_ones = 0;
    bit          rand_ready = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_word(int c);
        int v;
        v = (2 * c - 64) * 512;
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction

    task automatic reset_model();
        mq.delete();
        m_ovr = 0; m_pend = 0; m_idx = 0; m_ones = 0;
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit pop, full, push;
        if (!reset) return;
        pop  = (mq.size() != 0) && pcm_ready;
        full = (mq.size() == 4);
        push = m_pend;
        if (pop) void'(mq.pop_front());
        if (push && full && !pop) m_ovr = 1;
        else begin
            if (push) mq.push_back(m_pend_w);
            if (clr_ovr) m_ovr = 0;
        end
        m_pend = 0;
        if (!en) begin
            m_idx = 0; m_ones = 0;
        end else if (mclk_en) begin
            m_ones += int'(pdm_bit);
            m_idx++;
            if (m_idx == 64) begin
                m_pend = 1; m_pend_w = ref_word(m_ones);
                m_idx = 0; m_ones = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", pcm_valid, (mq.size() != 0));
        chk("level", fifo_level, mq.size());
        chk("overrun", overrun, m_ovr);
        if (mq.size() != 0) chk("data", pcm_data, mq[0]);
    endtask

    task automatic tick();
        if (rand_ready) pcm_ready = 1'($urandom_range(0, 1));
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send_bit(bit b, int gap);
        mclk_en = 1'b1; pdm_bit = b;
        tick();
        mclk_en = 1'b0; pdm_bit = 1'($urandom_range(0, 1));
        repeat (gap) tick();
    endtask

    // kind: 0 ones, 1 zeros, 2 alternating, 3 48 ones then 16 zeros, 4 random
    task automatic send_window(int kind);
        bit b;
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0: b = 1;
                1: b = 0;
                2: b = (i % 2 == 0);
                3: b = (i < 48);
                default: b = 1'($urandom_range(0, 1));
            endcase
            send_bit(b, (i == 63) ? 0 : int'($urandom_range(0, 1)));
        end
    endtask

    task automatic pop_one();
        pcm_ready = 1'b1; tick(); pcm_ready = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", pcm_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_data", pcm_data, 0);
        reset = 1'b1; en = 1'b1;
        tick();

        send_window(0); tick(); chk("t1_ones", pcm_data, 16'h7FFF); pop_one();
        send_window(1); tick(); chk("t1_zeros", pcm_data, 16'h8000); pop_one();
        send_window(2); tick(); chk("t1_alt", pcm_data, 16'h0000); pop_one();

        send_window(3);
        chk("t2_lat0", pcm_valid, 0);
        tick();
        chk("t2_lat1", pcm_valid, 1);
        chk("t2_word", pcm_data, 16'h4000);
        pop_one();

        repeat (5) send_window(4);
        tick();
        chk("t3_level", fifo_level, 4);
        chk("t3_ovr", overrun, 1);
        pcm_ready = 1'b1; repeat (4) tick(); pcm_ready = 1'b0;
        chk("t3_drained", fifo_level, 0);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("t3_clr", overrun, 0);

        repeat (4) send_window(4);
        tick();
        chk("t4_full", fifo_level, 4);
        send_window(4);
        pcm_ready = 1'b1; tick(); pcm_ready = 1'b0;
        chk("t4_level", fifo_level, 4);
        chk("t4_ovr", overrun, 0);
        pcm_ready = 1'b1; repeat (4) tick(); pcm_ready = 1'b0;

        repeat (5) send_window(4);
        tick();
        for (int i = 0; i < 30; i++) send_bit(1, 0);
        #2 reset = 1'b0;
        #1;
        chk("t5_valid", pcm_valid, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_ovr", overrun, 0);
        chk("t5_data", pcm_data, 0);
        reset_model();
        tick();
        reset = 1'b1;
        tick();
        send_window(0); tick(); chk("t5_fresh", pcm_data, 16'h7FFF); pop_one();

        for (int i = 0; i < 20; i++) send_bit(1, 0);
        en = 1'b0; repeat (3) tick(); en = 1'b1;
        send_window(2); tick();
        chk("t6_level", fifo_level, 1);
        chk("t6_word", pcm_data, 16'h0000);
        pop_one();

        rand_ready = 1;
        repeat (8) send_window(4);
        rand_ready = 0;
        pcm_ready = 1'b1; repeat (8) tick(); pcm_ready = 1'b0;
        chk("end_empty", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
